// File: rtl/bp_counter_update.sv
// bp_counter_update: queued commit-time 2-bit counter update engine; BP_COUNTER_UPDATE_FWD_EN enables stage-2 forwarding
module bp_counter_update #(
    parameter int SRAM_DEPTH      = 64,
    parameter int SRAM_INDEX      = 6,
    parameter int SRAM_WIDTH      = 2,
    parameter int UPD_QUEUE_DEPTH = 4,
    parameter int UPD_QUEUE_INDEX = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       updValid_i,
    input  logic [SRAM_INDEX-1:0]      updIndex_i,
    input  logic                       updTaken_i,
    output logic                       updReady_o,
    input  logic                       hold_i,
    output logic                       re1_o,
    output logic [SRAM_INDEX-1:0]      addr1_o,
    input  logic [SRAM_WIDTH-1:0]      data1_i,
    output logic                       we_o,
    output logic [SRAM_INDEX-1:0]      addrWr_o,
    output logic [SRAM_WIDTH-1:0]      data_o,
    output logic                       busy_o,
    output logic [UPD_QUEUE_INDEX:0]   queueCount_o
);
    if (SRAM_WIDTH != 2 || (1 << SRAM_INDEX) != SRAM_DEPTH || (1 << UPD_QUEUE_INDEX) != UPD_QUEUE_DEPTH) begin : g_bad_cfg
        bp_counter_update_unsupported_config u_bad ();
    end
    logic [SRAM_INDEX-1:0]      r_qIdx [UPD_QUEUE_DEPTH];
    logic [UPD_QUEUE_DEPTH-1:0] r_qTkn;
    logic [UPD_QUEUE_INDEX-1:0] r_head, r_tail;
    logic [UPD_QUEUE_INDEX:0]   r_count;
    logic                       r_s2Valid, r_s2Taken;
    logic [SRAM_INDEX-1:0]      r_s2Index;
    logic [SRAM_WIDTH-1:0]      r_s2Old;
    logic [SRAM_INDEX-1:0]      w_headIdx;
    logic [SRAM_WIDTH-1:0]      w_s2New, w_old;
    logic                       w_full, w_nonEmpty, w_push, w_hit, w_stall, w_issue;
    assign w_headIdx  = r_qIdx[r_head];
    assign w_full     = r_count == (UPD_QUEUE_INDEX+1)'(UPD_QUEUE_DEPTH);
    assign w_nonEmpty = r_count != '0;
    assign w_push     = updValid_i & ~w_full;
    assign w_s2New    = r_s2Taken ? ((&r_s2Old) ? r_s2Old : r_s2Old + 1'b1)
                                  : ((|r_s2Old) ? r_s2Old - 1'b1 : r_s2Old);
    // Stage 2 commits at the same edge stage 1 reads, so a same-index read would be stale.
    assign w_hit      = r_s2Valid & (r_s2Index == w_headIdx);
`ifdef BP_COUNTER_UPDATE_FWD_EN
    assign w_stall    = hold_i;
    assign w_old      = w_hit ? w_s2New : data1_i;
`else
    assign w_stall    = hold_i | w_hit;
    assign w_old      = data1_i;
`endif
    assign w_issue    = w_nonEmpty & ~w_stall;
    assign updReady_o   = reset | ~w_full;
    assign re1_o        = ~reset & w_issue;
    assign addr1_o      = (reset | ~w_nonEmpty) ? '0 : w_headIdx;
    assign we_o         = ~reset & r_s2Valid & (w_s2New != r_s2Old);
    assign addrWr_o     = reset ? '0 : r_s2Index;
    assign data_o       = reset ? '0 : w_s2New;
    assign busy_o       = ~reset & (w_nonEmpty | r_s2Valid);
    assign queueCount_o = reset ? '0 : r_count;
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_qIdx[r_tail] <= updIndex_i;
            r_qTkn[r_tail] <= updTaken_i;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            r_head    <= '0;
            r_tail    <= '0;
            r_count   <= '0;
            r_s2Valid <= 1'b0;
            r_s2Index <= '0;
            r_s2Taken <= 1'b0;
            r_s2Old   <= '0;
        end else begin
            if (w_push) r_tail <= r_tail + 1'b1;
            if (w_issue) r_head <= r_head + 1'b1;
            r_count   <= r_count + (UPD_QUEUE_INDEX+1)'(w_push) - (UPD_QUEUE_INDEX+1)'(w_issue);
            r_s2Valid <= w_issue;
            if (w_issue) begin
                r_s2Index <= w_headIdx;
                r_s2Taken <= r_qTkn[r_head];
                r_s2Old   <= w_old;
            end
        end
    end
endmodule

// File: tb/tb_bp_counter_update.sv
// tb_bp_counter_update: directed and random checks of bp_counter_update against a sequential counter-table model
module tb_bp_counter_update;
`ifdef BP_COUNTER_UPDATE_FWD_EN
    localparam int HAZ_BUSY = 4;
`else
    localparam int HAZ_BUSY = 6;
`endif
    logic       clk = 1'b0;
    logic       reset, updValid_i, updTaken_i, hold_i, arr_clr;
    logic [5:0] updIndex_i, addr1_o, addrWr_o;
    logic       updReady_o, re1_o, we_o, busy_o;
    logic [1:0] data1_i, data_o;
    logic [2:0] queueCount_o;
    logic [1:0] arr [64];
    int         mdl [64];
    int         snap [64];
    logic [7:0] expq [$];
    int         pass_n = 0, total_n = 0, wr_n = 0;

    bp_counter_update dut (
        .clk(clk), .reset(reset), .updValid_i(updValid_i), .updIndex_i(updIndex_i),
        .updTaken_i(updTaken_i), .updReady_o(updReady_o), .hold_i(hold_i), .re1_o(re1_o),
        .addr1_o(addr1_o), .data1_i(data1_i), .we_o(we_o), .addrWr_o(addrWr_o),
        .data_o(data_o), .busy_o(busy_o), .queueCount_o(queueCount_o)
    );

    always #5 clk = ~clk;
    assign data1_i = arr[addr1_o];

    always @(posedge clk) begin
        if (arr_clr) for (int i = 0; i < 64; i++) arr[i] <= 2'b10;
        else if (we_o) arr[addrWr_o] <= data_o;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_n++;
        assert (obs === exp) pass_n++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Every write must match the next change predicted by applying updates in commit order.
    always @(negedge clk) begin
        if (we_o === 1'b1) begin
            wr_n++;
            if (expq.size() == 0) check("spurious_wr", we_o, 0);
            else begin
                logic [7:0] e;
                e = expq.pop_front();
                check("wr_addr", addrWr_o, e[7:2]);
                check("wr_data", data_o, e[1:0]);
            end
        end
    end

    task automatic model_push(input logic [5:0] idx, input logic tk);
        int v, n;
        v = mdl[idx];
        n = tk ? ((v + 1 > 3) ? 3 : v + 1) : ((v - 1 < 0) ? 0 : v - 1);
        if (n != v) expq.push_back({idx, 2'(n)});
        mdl[idx] = n;
    endtask

    task automatic drive(input logic v, input logic [5:0] idx, input logic tk, input logic h);
        @(posedge clk);
        #1;
        updValid_i = v; updIndex_i = idx; updTaken_i = tk; hold_i = h;
        @(negedge clk);
        if (v && updReady_o && !reset) model_push(idx, tk);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(0, 0, 0, 0);
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy_o && k < 40) begin
            drive(0, 0, 0, 0);
            k++;
        end
        check("idle_busy", busy_o, 0);
        check("idle_expq", expq.size(), 0);
    endtask

    initial begin
        int w0, bc;
        reset = 1; arr_clr = 1; updValid_i = 0; updIndex_i = 0; updTaken_i = 0; hold_i = 0;
        for (int i = 0; i < 64; i++) mdl[i] = 2;
        @(negedge clk);
        check("rst_ready", updReady_o, 1);
        check("rst_re1", re1_o, 0);
        check("rst_we", we_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_count", queueCount_o, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 0; arr_clr = 0;
        @(negedge clk);
        check("post_ready", updReady_o, 1);
        check("post_re1", re1_o, 0);
        check("post_we", we_o, 0);
        check("post_busy", busy_o, 0);
        check("post_count", queueCount_o, 0);
        check("post_addr1", addr1_o, 0);
        check("post_addrwr", addrWr_o, 0);
        check("post_data", data_o, 0);

        drive(1, 5, 1, 0);
        drive(0, 0, 0, 0);
        check("one_re1", re1_o, 1);
        check("one_addr1", addr1_o, 5);
        drive(0, 0, 0, 0);
        check("one_we", we_o, 1);
        check("one_addrwr", addrWr_o, 5);
        check("one_data", data_o, 3);
        drive(0, 0, 0, 0);
        check("one_arr", arr[5], 3);

        w0 = wr_n;
        drive(1, 5, 1, 0);
        idle(4);
        check("sat_hi_nowr", wr_n - w0, 0);
        drive(1, 7, 0, 0);
        drive(1, 7, 0, 0);
        wait_idle();
        check("sat_lo_arr", arr[7], 0);
        w0 = wr_n;
        drive(1, 7, 0, 0);
        idle(4);
        check("sat_lo_nowr", wr_n - w0, 0);

        wait_idle();
        w0 = wr_n;
        drive(1, 9, 0, 0);
        drive(1, 9, 0, 0);
        check("haz_busy1", busy_o, 1);
        drive(1, 9, 0, 0);
        check("haz_busy2", busy_o, 1);
        bc = 2;
        for (int k = 0; k < 20; k++) begin
            drive(0, 0, 0, 0);
            if (busy_o) bc++;
            else break;
        end
        check("haz_busy_cycles", bc, HAZ_BUSY);
        check("haz_writes", wr_n - w0, 2);
        check("haz_arr", arr[9], 0);

        wait_idle();
        for (int i = 0; i < 5; i++) begin
            drive(1, 6'(30 + i), 1, 1);
            check("full_ready", updReady_o, i < 4);
        end
        check("full_count", queueCount_o, 4);
        for (int j = 0; j < 4; j++) begin
            drive(0, 0, 0, 0);
            check("drain_re1", re1_o, 1);
            check("drain_addr1", addr1_o, 30 + j);
        end
        drive(0, 0, 0, 0);
        check("drain_re1_off", re1_o, 0);
        check("drain_busy_hi", busy_o, 1);
        drive(0, 0, 0, 0);
        check("drain_busy_lo", busy_o, 0);

        wait_idle();
        for (int i = 0; i < 64; i++) snap[i] = mdl[i];
        for (int i = 0; i < 4; i++) drive(1, 6'(20 + i), 1, 1);
        drive(0, 0, 0, 0);
        check("mid_issue", re1_o, 1);
        check("mid_count", queueCount_o, 4);
        @(posedge clk);
        #1;
        reset = 1; hold_i = 1;
        @(negedge clk);
        check("mid_rst_we", we_o, 0);
        check("mid_rst_re1", re1_o, 0);
        check("mid_rst_ready", updReady_o, 1);
        check("mid_rst_count", queueCount_o, 0);
        check("mid_rst_busy", busy_o, 0);
        for (int i = 0; i < 64; i++) mdl[i] = snap[i];
        expq.delete();
        @(posedge clk);
        #1;
        reset = 0; hold_i = 0;
        @(negedge clk);
        check("mid_post_count", queueCount_o, 0);
        check("mid_post_busy", busy_o, 0);
        w0 = wr_n;
        idle(4);
        check("mid_no_wr", wr_n - w0, 0);
        for (int i = 20; i < 24; i++) check("mid_arr", arr[i], snap[i]);

        repeat (300) drive($urandom_range(0, 3) != 0, 6'($urandom_range(0, 7)), 1'($urandom), $urandom_range(0, 7) == 0);
        wait_idle();
        for (int i = 0; i < 64; i++) check("final_arr", arr[i], mdl[i]);

        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end
endmodule

// File: doc/bp_counter_update.md
# bp_counter_update

- Commit-time update engine for the 2-bit branch-direction counter table held in the SRAM_2R1W-style predictor array.
- Buffers resolved branch outcomes in a small queue and reads the current counter through the array's second read port. It computes the saturating update and writes the result back through the array's single write port.
- Sits between the commit stage (upstream) and the counter array (downstream).
- It is the only writer of the table.

## Interface
Parameters:
- SRAM_DEPTH, 64, counter table entries
- SRAM_INDEX, 6, log2(SRAM_DEPTH)
- SRAM_WIDTH, 2, counter width; only 2 is supported
- UPD_QUEUE_DEPTH, 4, update queue entries (power of 2)
- UPD_QUEUE_INDEX, 2, log2(UPD_QUEUE_DEPTH)

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock, all state updates on posedge
- reset  in  1  synchronous, active-high
- updValid_i  in  1  commit presents an update
- updIndex_i  in  SRAM_INDEX  counter index
- updTaken_i  in  1  resolved direction (1 = taken)
- updReady_o  out  1  queue can accept; update accepted when updValid_i & updReady_o at posedge
- hold_i  in  1  suppress issue from queue (predictor recovery); queue still accepts
- re1_o  out  1  read enable to array read port 1
- addr1_o  out  SRAM_INDEX  read address to array read port 1
- data1_i  in  SRAM_WIDTH  combinational read data from port 1
- we_o  out  1  array write enable
- addrWr_o  out  SRAM_INDEX  array write address
- data_o  out  SRAM_WIDTH  array write data
- busy_o  out  1  queue non-empty or stage 2 valid
- queueCount_o  out  UPD_QUEUE_INDEX+1  queue occupancy

## Operation
- Counter encoding:
  - 00 = strong not-taken, 01 = weak NT, 10 = weak T, 11 = strong T.
  - The array resets every entry to 10.
- Queue:
  - Circular FIFO with head and tail pointers that wrap modulo UPD_QUEUE_DEPTH, plus an occupancy count.
  - updReady_o = (count != UPD_QUEUE_DEPTH); it does not depend on a same-cycle pop.
  - Push and pop in the same cycle leave count unchanged.
- Stage 1 (read/issue):
  - When the queue is non-empty and not stalled: re1_o=1, addr1_o = head index, and the head is popped at the edge.
  - Old value = data1_i, or the forwarded stage-2 new value (see Configuration).
  - The entry is captured into the stage-2 registers: s2Valid, s2Index, s2Taken, s2Old.
  - Stalled when hold_i=1, or when a hazard is stalled (no-forwarding build only).
  - When stalled or the queue is empty: re1_o=0 and addr1_o holds the head index, don't-care.
- Stage 2 (modify/write):
  - s2New = s2Taken ? min(s2Old+1, 3) : max(s2Old-1, 0).
  - we_o = s2Valid & (s2New != s2Old); a saturated, unchanged counter is not written.
  - addrWr_o = s2Index, data_o = s2New.
  - s2Valid clears when no issue occurs that cycle.
- Hazard: stage 1 reading index X while stage 2 writes X sees the stale value, because the array commits at the same edge.
- Reset:
  - Clears count, both pointers and s2Valid.
  - All queued and in-flight updates are dropped, with no write in the reset cycle or after it.
  - Outputs during and after reset: updReady_o=1, re1_o=0, we_o=0, busy_o=0, queueCount_o=0, addr1_o/addrWr_o/data_o=0.

## Timing
- An update accepted at edge E0, with an empty queue and stage 2 free, moves as follows:
  - re1_o is high in the cycle after E0, and the entry enters stage 2 at E1.
  - we_o is high in the cycle after E1, and the array holds the new value after E2.
- Latency: 2 cycles from accept to write-enable cycle.
- Throughput: 1 update per cycle with forwarding.
- Without forwarding: +1 bubble per back-to-back same-index pair.
- hold_i takes effect in the same cycle: no issue while it is high, and stage 2 drains normally.

## Configuration
- Macro: BP_COUNTER_UPDATE_FWD_EN.
- Defined:
  - If s2Valid & (s2Index == head index), stage 1 uses s2New instead of data1_i as its old value.
  - No stall.
- Undefined:
  - Under the same condition, stage 1 stalls for one cycle (re1_o=0, no pop).
  - Stage 2 writes, and stage 1 reads the updated array the next cycle.
- Final array contents are identical in both builds; only timing differs.

## Test plan
- Reset check: hold reset 2 cycles, then release. Expect updReady_o=1, re1_o=0, we_o=0, busy_o=0, queueCount_o=0, and no write afterwards.
- Single update: index 5 (array value 10), taken, accepted at E0. Expect re1_o=1/addr1_o=5 in cycle E0+1, then we_o=1/addrWr_o=5/data_o=11 in cycle E1+1.
- Saturation: index 5 = 11, taken. Expect no we_o pulse; index 7 = 00, not-taken, also gives no write.
- Back-to-back hazard: three not-taken updates to index 9 (value 10) on consecutive cycles. Expect writes 01 then 00, no third write, and final value 00 in both builds. The no-forwarding build takes 2 extra cycles (one bubble per same-index pair).
- Queue full: hold_i=1 with 5 consecutive pushes. Expect 4 accepted, updReady_o=0 and queueCount_o=4 on the 5th. Then release hold_i: 4 issues on consecutive cycles and busy_o low 2 cycles after the last issue.
- Reset mid-operation: 3 entries queued and stage 2 valid, then assert reset for 1 cycle. Expect we_o=0 in that cycle and after, queueCount_o=0, and array contents unchanged by the dropped updates.
